vga_rx: RTL and testbench



---
 rtl/vga_rx.sv | 199 +++++++++++++++++++
 tb/tb_vga_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx.sv
// Receive-side VGA decoder: samples the GPU's VGA bus on pixel-clock rising edges
// and produces a coordinate-tagged pixel stream plus per-frame checksum and geometry status.
module vga_rx #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [31:0] frame_sum,
  output logic        line_err
);

  typedef enum logic {SEEK, FRAME} state_t;

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        clk_q, clk_d;
  logic        vs_prev_q, vs_prev_d;
  logic        hs_prev_q, hs_prev_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [31:0] sum_q, sum_d;
  logic        prev_act_q, prev_act_d;
  logic        line_err_q, line_err_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [10:0] pix_y_q, pix_y_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [31:0] frame_sum_q, frame_sum_d;

  logic        stb, vs_act, hs_act, vs_edge, hs_edge;
  logic [10:0] x_cur, x_nxt, y_nxt, lines;
  logic [31:0] sum_nxt;
  logic        prev_nxt, err_nxt, trunc;

  assign stb     = VGA_CLK & ~clk_q;
  assign vs_act  = VGA_VS ^ SYNC_ACTIVE_LOW;
  assign hs_act  = VGA_HS ^ SYNC_ACTIVE_LOW;
  assign vs_edge = stb & vs_act & ~vs_prev_q;
  assign hs_edge = stb & hs_act & ~hs_prev_q;

  always_comb begin
    clk_d         = VGA_CLK;
    state_d       = state_q;
    vs_prev_d     = vs_prev_q;
    hs_prev_d     = hs_prev_q;
    x_d           = x_q;
    y_d           = y_q;
    sum_d         = sum_q;
    prev_act_d    = prev_act_q;
    line_err_d    = line_err_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    frame_sum_d   = frame_sum_q;
    x_cur         = hs_edge ? 11'd0 : x_q;
    x_nxt         = x_cur;
    y_nxt         = y_q;
    sum_nxt       = sum_q;
    prev_nxt      = prev_act_q;
    err_nxt       = line_err_q;
    trunc         = 1'b0;
    lines         = 11'd0;

    if (stb) begin
      vs_prev_d = vs_act;
      hs_prev_d = hs_act;
    end

    case (state_q)
      SEEK: begin
        if (vs_edge) begin
          state_d       = FRAME;
          frame_start_d = 1'b1;
          x_d           = 11'd0;
          y_d           = 11'd0;
          sum_d         = 32'd0;
          prev_act_d    = 1'b0;
          line_err_d    = 1'b0;
        end
      end
      FRAME: begin
        if (stb) begin
          if (VGA_BLANK_N) begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_cur;
            pix_y_d     = y_q;
            pix_rgb_d   = {VGA_R, VGA_G, VGA_B};
            x_nxt       = x_cur + 11'd1;
            sum_nxt     = sum_q + {8'h00, VGA_R, VGA_G, VGA_B};
            prev_nxt    = 1'b1;
          end else if (prev_act_q) begin
            // Line length is judged on the pixels actually received in this line.
            if (x_q != H_LIM) err_nxt = 1'b1;
            y_nxt    = y_q + 11'd1;
            x_nxt    = 11'd0;
            prev_nxt = 1'b0;
          end

          if (vs_edge) begin
            // A line still active when VS arrives is truncated but still counted.
            trunc         = prev_act_q & VGA_BLANK_N;
            lines         = y_nxt + {10'd0, trunc};
            frame_done_d  = 1'b1;
            frame_ok_d    = (lines == V_LIM) && !(err_nxt || trunc);
            frame_sum_d   = sum_nxt;
            frame_start_d = 1'b1;
            x_d           = 11'd0;
            y_d           = 11'd0;
            sum_d         = 32'd0;
            prev_act_d    = 1'b0;
            line_err_d    = 1'b0;
          end else begin
            x_d        = x_nxt;
            y_d        = y_nxt;
            sum_d      = sum_nxt;
            prev_act_d = prev_nxt;
            line_err_d = err_nxt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q       <= SEEK;
      clk_q         <= 1'b0;
      vs_prev_q     <= 1'b0;
      hs_prev_q     <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      sum_q         <= 32'd0;
      prev_act_q    <= 1'b0;
      line_err_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 11'd0;
      pix_y_q       <= 11'd0;
      pix_rgb_q     <= 24'd0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_sum_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      clk_q         <= clk_d;
      vs_prev_q     <= vs_prev_d;
      hs_prev_q     <= hs_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sum_q         <= sum_d;
      prev_act_q    <= prev_act_d;
      line_err_q    <= line_err_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      frame_sum_q   <= frame_sum_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_sum   = frame_sum_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_vga_rx.sv
// Self-checking bench for vga_rx: two instances (active-low and active-high syncs)
// share one stimulus stream; a scoreboard checks pixels and frame results on both.
module tb_vga_rx;

  localparam int H = 4;
  localparam int V = 3;
  localparam logic [31:0] CLEAN_SUM = 32'h0012_0C0C;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
  } pix_t;

  typedef struct {
    logic        ok;
    logic [31:0] sum;
  } frame_t;

  typedef struct {
    int          n_lines;
    int          short_line;
    int          short_len;
    logic        exp_err;
    logic        exp_ok;
    logic [31:0] exp_sum;
  } frame_vec_t;

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       vga_clk  = 1'b0;
  logic       hs_act   = 1'b0;
  logic       vs_act   = 1'b0;
  logic       blank_n  = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;

  logic        pix_valid_o   [2];
  logic [10:0] pix_x_o       [2];
  logic [10:0] pix_y_o       [2];
  logic [23:0] pix_rgb_o     [2];
  logic        frame_start_o [2];
  logic        frame_done_o  [2];
  logic        frame_ok_o    [2];
  logic [31:0] frame_sum_o   [2];
  logic        line_err_o    [2];

  pix_t       pix_q   [2][$];
  frame_t     frame_q [2][$];
  int         starts  [2];
  int         exp_starts = 0;
  int         checks     = 0;
  int         failures   = 0;
  frame_vec_t vecs [4];

  always #5 clock_50 = ~clock_50;

  vga_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b1)) dut_lo (
    .CLOCK_50(clock_50), .RESET(reset), .VGA_CLK(vga_clk),
    .VGA_HS(~hs_act), .VGA_VS(~vs_act), .VGA_BLANK_N(blank_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .pix_valid(pix_valid_o[0]), .pix_x(pix_x_o[0]), .pix_y(pix_y_o[0]),
    .pix_rgb(pix_rgb_o[0]), .frame_start(frame_start_o[0]),
    .frame_done(frame_done_o[0]), .frame_ok(frame_ok_o[0]),
    .frame_sum(frame_sum_o[0]), .line_err(line_err_o[0])
  );

  vga_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
    .CLOCK_50(clock_50), .RESET(reset), .VGA_CLK(vga_clk),
    .VGA_HS(hs_act), .VGA_VS(vs_act), .VGA_BLANK_N(blank_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .pix_valid(pix_valid_o[1]), .pix_x(pix_x_o[1]), .pix_y(pix_y_o[1]),
    .pix_rgb(pix_rgb_o[1]), .frame_start(frame_start_o[1]),
    .frame_done(frame_done_o[1]), .frame_ok(frame_ok_o[1]),
    .frame_sum(frame_sum_o[1]), .line_err(line_err_o[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One pixel-clock period: VGA_CLK high for one CLOCK_50 cycle, then low for one.
  task automatic applyStimulus(input logic bl, input logic hs, input logic vs,
                               input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    @(negedge clock_50);
    vga_clk = 1'b1;
    blank_n = bl;
    hs_act  = hs;
    vs_act  = vs;
    r       = rr;
    g       = gg;
    b       = bb;
    @(negedge clock_50);
    vga_clk = 1'b0;
  endtask

  task automatic pushPix(input int xi, input int yi);
    pix_t p;
    p.x   = 11'(xi);
    p.y   = 11'(yi);
    p.rgb = {8'(xi), 8'(yi), 8'h01};
    for (int d = 0; d < 2; d++) pix_q[d].push_back(p);
  endtask

  task automatic sendLine(input int yi, input int n_pix, input bit exp_pix);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA, 8'h55, 8'hAA);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'hAA);
    for (int xi = 0; xi < n_pix; xi++) begin
      if (exp_pix) pushPix(xi, yi);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(xi), 8'(yi), 8'h01);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'hAA);
  endtask

  task automatic sendVs(input bit exp_done, input logic ok, input logic [31:0] sum);
    frame_t f;
    f.ok  = ok;
    f.sum = sum;
    if (exp_done) for (int d = 0; d < 2; d++) frame_q[d].push_back(f);
    exp_starts++;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
  endtask

  task automatic checkIdle(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s pix_valid[%0d]", tag, d), 32'(pix_valid_o[d]), 32'd0);
      checkOutput($sformatf("%s pix_x[%0d]", tag, d), 32'(pix_x_o[d]), 32'd0);
      checkOutput($sformatf("%s pix_y[%0d]", tag, d), 32'(pix_y_o[d]), 32'd0);
      checkOutput($sformatf("%s pix_rgb[%0d]", tag, d), 32'(pix_rgb_o[d]), 32'd0);
      checkOutput($sformatf("%s frame_start[%0d]", tag, d), 32'(frame_start_o[d]), 32'd0);
      checkOutput($sformatf("%s frame_done[%0d]", tag, d), 32'(frame_done_o[d]), 32'd0);
      checkOutput($sformatf("%s frame_ok[%0d]", tag, d), 32'(frame_ok_o[d]), 32'd0);
      checkOutput($sformatf("%s frame_sum[%0d]", tag, d), frame_sum_o[d], 32'd0);
      checkOutput($sformatf("%s line_err[%0d]", tag, d), 32'(line_err_o[d]), 32'd0);
    end
  endtask

  // Scoreboard: every DUT output pulse is matched against the queued expectation.
  always @(negedge clock_50) begin
    for (int d = 0; d < 2; d++) begin
      if (pix_valid_o[d]) begin
        if (pix_q[d].size() == 0) begin
          checkOutput($sformatf("unexpected pix_valid[%0d]", d), 32'd1, 32'd0);
        end else begin
          pix_t p;
          p = pix_q[d].pop_front();
          checkOutput($sformatf("pix_x[%0d]", d), 32'(pix_x_o[d]), 32'(p.x));
          checkOutput($sformatf("pix_y[%0d]", d), 32'(pix_y_o[d]), 32'(p.y));
          checkOutput($sformatf("pix_rgb[%0d]", d), 32'(pix_rgb_o[d]), 32'(p.rgb));
        end
      end
      if (frame_done_o[d]) begin
        if (frame_q[d].size() == 0) begin
          checkOutput($sformatf("unexpected frame_done[%0d]", d), 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = frame_q[d].pop_front();
          checkOutput($sformatf("frame_ok[%0d]", d), 32'(frame_ok_o[d]), 32'(f.ok));
          checkOutput($sformatf("frame_sum[%0d]", d), frame_sum_o[d], f.sum);
        end
      end
      if (frame_start_o[d]) starts[d]++;
    end
  end

  initial begin
    vecs[0] = '{n_lines: 3, short_line: -1, short_len: H, exp_err: 1'b0, exp_ok: 1'b1, exp_sum: CLEAN_SUM};
    vecs[1] = '{n_lines: 3, short_line:  1, short_len: 3, exp_err: 1'b1, exp_ok: 1'b0, exp_sum: 32'h000F_0B0B};
    vecs[2] = '{n_lines: 2, short_line: -1, short_len: H, exp_err: 1'b0, exp_ok: 1'b0, exp_sum: 32'h000C_0408};
    vecs[3] = '{n_lines: 3, short_line: -1, short_len: H, exp_err: 1'b0, exp_ok: 1'b1, exp_sum: CLEAN_SUM};
    starts[0] = 0;
    starts[1] = 0;

    repeat (3) @(negedge clock_50);
    checkIdle("reset");
    reset = 1'b0;

    // Startup: video and HS before any VS must be ignored; first VS only opens a frame.
    sendLine(0, H, 1'b0);
    sendLine(1, H, 1'b0);
    sendVs(1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 4; i++) begin
      for (int yi = 0; yi < vecs[i].n_lines; yi++)
        sendLine(yi, (yi == vecs[i].short_line) ? vecs[i].short_len : H, 1'b1);
      for (int d = 0; d < 2; d++)
        checkOutput($sformatf("vec%0d line_err before VS[%0d]", i, d), 32'(line_err_o[d]), 32'(vecs[i].exp_err));
      sendVs(1'b1, vecs[i].exp_ok, vecs[i].exp_sum);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("vec%0d line_err after VS[%0d]", i, d), 32'(line_err_o[d]), 32'd0);
        checkOutput($sformatf("vec%0d frame_ok hold[%0d]", i, d), 32'(frame_ok_o[d]), 32'(vecs[i].exp_ok));
        checkOutput($sformatf("vec%0d frame_sum hold[%0d]", i, d), frame_sum_o[d], vecs[i].exp_sum);
      end
    end

    // Mid-frame reset during line 1: partial frame is dropped, next full frame is good.
    sendLine(0, H, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA, 8'h55, 8'hAA);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'hAA);
    for (int xi = 0; xi < 2; xi++) begin
      pushPix(xi, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(xi), 8'd1, 8'h01);
    end
    @(negedge clock_50);
    reset = 1'b1;
    #1;
    checkIdle("mid-frame reset");
    @(negedge clock_50);
    reset = 1'b0;
    for (int xi = 2; xi < H; xi++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(xi), 8'd1, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'hAA);
    sendLine(2, H, 1'b0);
    sendVs(1'b0, 1'b0, 32'd0);
    for (int yi = 0; yi < V; yi++) sendLine(yi, H, 1'b1);
    sendVs(1'b1, 1'b1, CLEAN_SUM);
    repeat (4) @(negedge clock_50);

    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("pixels outstanding[%0d]", d), 32'(pix_q[d].size()), 32'd0);
      checkOutput($sformatf("frames outstanding[%0d]", d), 32'(frame_q[d].size()), 32'd0);
      checkOutput($sformatf("frame_start count[%0d]", d), 32'(starts[d]), 32'(exp_starts));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
